// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, bus bit levels, data width.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_BYTE   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_BYTE   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_target_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   I2C_DATA_W = 24;
  localparam logic [3:0] I2C_BITS_PER_BYTE = 4'd8;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    sat_inc2 = (v == 2'd3) ? 2'd3 : (v + 2'd1);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Samples scl/sda and flags scl edges plus START/STOP conditions.
// Define I2C_TARGET_SYNC_EN to insert a 2-flop synchroniser ahead of edge detection.
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_bit
);

  logic scl_s;
  logic sda_s;
  logic scl_q;
  logic sda_q;

`ifdef I2C_TARGET_SYNC_EN
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;

  // Two-stage synchroniser, idles released (high)
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`else
  assign scl_s = scl;
  assign sda_s = sda_in;
`endif

  // History registers for edge and condition detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  // A simultaneous scl/sda change never qualifies as START/STOP since scl_q must equal scl_s
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign sda_bit   = sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, 3-byte write into rx_data, 3-byte read from tx_data.
// Optional I2C_TARGET_SYNC_EN (see i2c_bus_monitor) adds input synchronisation.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         NUM_BYTES   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_out,
  input  logic [I2C_DATA_W-1:0] tx_data,
  output logic [I2C_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  addr_hit
);

  localparam logic [1:0] NB      = 2'(NUM_BYTES);
  localparam logic [1:0] NB_LAST = 2'(NUM_BYTES - 1);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_bit;

  i2c_target_state_t     state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            addr_sr_q, addr_sr_d;
  logic [I2C_DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [I2C_DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic                  rw_q, rw_d;
  logic                  sda_out_q, sda_out_d;
  logic [I2C_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q, busy_d;
  logic                  addr_hit_q, addr_hit_d;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_bit   (sda_bit)
  );

  // State, counters, shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      byte_cnt_q <= 2'd0;
      addr_sr_q  <= 8'h00;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      rw_q       <= 1'b0;
      sda_out_q  <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      addr_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_sr_q  <= addr_sr_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      rw_q       <= rw_d;
      sda_out_q  <= sda_out_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      addr_hit_q <= addr_hit_d;
    end
  end

  // Next-state logic; bus conditions override per-state behaviour
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_sr_d  = addr_sr_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    rw_d       = rw_q;
    sda_out_d  = sda_out_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    addr_hit_d = addr_hit_q;

    if (stop_det) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 4'd0;
      byte_cnt_d = 2'd0;
      sda_out_d  = 1'b1;
      busy_d     = 1'b0;
      addr_hit_d = 1'b0;
    end else if (start_det) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = 4'd0;
      byte_cnt_d = 2'd0;
      sda_out_d  = 1'b1;
      busy_d     = 1'b1;
      addr_hit_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            addr_sr_d = {addr_sr_q[6:0], sda_bit};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && (bit_cnt_q == I2C_BITS_PER_BYTE)) begin
            bit_cnt_d = 4'd0;
            if (addr_sr_q[7:1] == TARGET_ADDR) begin
              sda_out_d  = I2C_ACK;
              addr_hit_d = 1'b1;
              rw_d       = addr_sr_q[0];
              state_d    = ST_ADDR_ACK;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else begin
            addr_sr_d = addr_sr_q;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              tx_sr_d   = tx_data;
              sda_out_d = tx_data[I2C_DATA_W-1];
              bit_cnt_d = 4'd1;
              state_d   = ST_RD_BYTE;
            end else begin
              sda_out_d = 1'b1;
              state_d   = ST_WR_BYTE;
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise) begin
            if (byte_cnt_q < NB) begin
              rx_sr_d = {rx_sr_q[I2C_DATA_W-2:0], sda_bit};
            end else begin
              rx_sr_d = rx_sr_q;
            end
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && (bit_cnt_q == I2C_BITS_PER_BYTE)) begin
            sda_out_d = (byte_cnt_q < NB) ? I2C_ACK : I2C_NACK;
            bit_cnt_d = 4'd0;
            state_d   = ST_WR_ACK;
          end else begin
            state_d = ST_WR_BYTE;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_out_d  = 1'b1;
            byte_cnt_d = sat_inc2(byte_cnt_q);
            state_d    = ST_WR_BYTE;
            if (byte_cnt_q == NB_LAST) begin
              rx_data_d  = rx_sr_q;
              rx_valid_d = 1'b1;
            end else begin
              rx_valid_d = 1'b0;
            end
          end else begin
            state_d = ST_WR_ACK;
          end
        end
        ST_RD_BYTE: begin
          // Rotation keeps the next bit at [22] so it is driven straight from the register
          if (scl_fall) begin
            if (bit_cnt_q == I2C_BITS_PER_BYTE) begin
              sda_out_d = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
            end else begin
              tx_sr_d   = {tx_sr_q[I2C_DATA_W-2:0], tx_sr_q[I2C_DATA_W-1]};
              sda_out_d = tx_sr_q[I2C_DATA_W-2];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_RD_BYTE;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if ((sda_bit == I2C_ACK) && (byte_cnt_q < NB_LAST)) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              state_d    = ST_RD_BYTE;
            end else begin
              sda_out_d = 1'b1;
              state_d   = ST_WAIT_STOP;
            end
          end else begin
            state_d = ST_RD_ACK;
          end
        end
        ST_WAIT_STOP: state_d = ST_WAIT_STOP;
        ST_IDLE:      state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  assign sda_out  = sda_out_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign addr_hit = addr_hit_q;

endmodule
